// File: rtl/gpr_sequencer.sv
// Control sequencer for the GPR datapath: fetch, decode, execute and memory phases.
// Strobes are decoded combinationally from the current state, IR, MRDY and COND.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, waiting for RUN
// S_FETCH  | read instruction at R7, load IR, increment PC
// S_DECODE | one cycle for IR to settle; branch on opcode
// S_EXEC   | single-cycle register operation (ALU/BR/JR/LI)
// S_MEM    | data memory access (LOAD/STORE), waits on MRDY
// S_HALT   | stopped by HALT opcode, RUN resumes at FETCH
// S_FAULT  | reserved opcode or memory timeout, sticky until reset
module gpr_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] IR,
    input  logic        MRDY,
    input  logic        COND,
    input  logic        RUN,
    output logic        IRLD,
    output logic        MREQ,
    output logic        MWE,
    output logic        REA,
    output logic        REA7,
    output logic        REB,
    output logic        RED2B,
    output logic        WED,
    output logic        WE7,
    output logic [1:0]  DSEL,
    output logic        HALTED,
    output logic        FAULT
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_BR    = 3'b011;
    localparam logic [2:0] OP_JR    = 3'b100;
    localparam logic [2:0] OP_LI    = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] DS_ALU = 2'd0;
    localparam logic [1:0] DS_MEM = 2'd1;
    localparam logic [1:0] DS_INC = 2'd2;
    localparam logic [1:0] DS_IMM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT,
        S_FAULT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      w_op;
    logic            w_timeout;
    logic            w_unused;

    assign w_op      = IR[15:13];
    assign w_timeout = (r_cnt == CW'(MEM_TIMEOUT));
    // Register fields are routed straight to the register file, not used here.
    assign w_unused  = ^IR[12:0];

    // The wait counter is only non-zero inside FETCH/MEM; every exit clears it,
    // so each entry into a memory phase starts from zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (RUN) r_state <= S_FETCH;
                end
                S_FETCH, S_MEM: begin
                    if (MRDY) begin
                        r_cnt   <= '0;
                        r_state <= (r_state == S_FETCH) ? S_DECODE : S_FETCH;
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    case (w_op)
                        OP_ALU, OP_BR, OP_JR, OP_LI: r_state <= S_EXEC;
                        OP_LOAD, OP_STORE:           r_state <= S_MEM;
                        OP_RSVD:                     r_state <= S_FAULT;
                        OP_HALT:                     r_state <= S_HALT;
                        default:                     r_state <= S_FAULT;
                    endcase
                end
                S_EXEC: r_state <= S_FETCH;
                S_HALT: begin
                    if (RUN) r_state <= S_FETCH;
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        IRLD   = 1'b0;
        MREQ   = 1'b0;
        MWE    = 1'b0;
        REA    = 1'b0;
        REA7   = 1'b0;
        REB    = 1'b0;
        RED2B  = 1'b0;
        WED    = 1'b0;
        WE7    = 1'b0;
        DSEL   = DS_ALU;
        HALTED = 1'b0;
        FAULT  = 1'b0;
        case (r_state)
            S_FETCH: begin
                REA7 = 1'b1;
                MREQ = 1'b1;
                if (MRDY) begin
                    IRLD = 1'b1;
                    WE7  = 1'b1;
                    DSEL = DS_INC;
                end
            end
            S_EXEC: begin
                case (w_op)
                    OP_ALU: begin
                        REA = 1'b1;
                        REB = 1'b1;
                        WED = 1'b1;
                    end
                    OP_BR: begin
                        REA7 = 1'b1;
                        DSEL = DS_IMM;
                        WE7  = COND;
                    end
                    OP_JR: begin
                        REA = 1'b1;
                        WE7 = 1'b1;
                    end
                    OP_LI: begin
                        WED  = 1'b1;
                        DSEL = DS_IMM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                case (w_op)
                    OP_LOAD: begin
                        REA  = 1'b1;
                        MREQ = 1'b1;
                        if (MRDY) begin
                            WED  = 1'b1;
                            DSEL = DS_MEM;
                        end
                    end
                    OP_STORE: begin
                        REA   = 1'b1;
                        RED2B = 1'b1;
                        MREQ  = 1'b1;
                        MWE   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT:  HALTED = 1'b1;
            S_FAULT: FAULT  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpr_sequencer.sv
// Self-checking bench for gpr_sequencer: directed scenarios plus random instruction
// streams, each instruction expanded into its expected per-cycle strobe sequence.
module tb_gpr_sequencer;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] IR;
    logic        MRDY, COND, RUN;
    logic        IRLD, MREQ, MWE, REA, REA7, REB, RED2B, WED, WE7, HALTED, FAULT;
    logic [1:0]  DSEL;

    gpr_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IR(IR), .MRDY(MRDY), .COND(COND), .RUN(RUN),
        .IRLD(IRLD), .MREQ(MREQ), .MWE(MWE), .REA(REA), .REA7(REA7), .REB(REB),
        .RED2B(RED2B), .WED(WED), .WE7(WE7), .DSEL(DSEL), .HALTED(HALTED), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    logic [12:0] obs;
    assign obs = {IRLD, MREQ, MWE, REA, REA7, REB, RED2B, WED, WE7, DSEL, HALTED, FAULT};

    localparam logic [12:0] ZERO     = 13'h0000;
    localparam logic [12:0] M_IRLD   = 13'h1000;
    localparam logic [12:0] M_MREQ   = 13'h0800;
    localparam logic [12:0] M_MWE    = 13'h0400;
    localparam logic [12:0] M_REA    = 13'h0200;
    localparam logic [12:0] M_REA7   = 13'h0100;
    localparam logic [12:0] M_REB    = 13'h0080;
    localparam logic [12:0] M_RED2B  = 13'h0040;
    localparam logic [12:0] M_WED    = 13'h0020;
    localparam logic [12:0] M_WE7    = 13'h0010;
    localparam logic [12:0] M_D1     = 13'h0004;
    localparam logic [12:0] M_D2     = 13'h0008;
    localparam logic [12:0] M_D3     = 13'h000C;
    localparam logic [12:0] M_HALTED = 13'h0002;
    localparam logic [12:0] M_FAULT  = 13'h0001;

    localparam logic [12:0] F_WAIT  = M_REA7 | M_MREQ;
    localparam logic [12:0] F_DONE  = M_REA7 | M_MREQ | M_IRLD | M_WE7 | M_D2;
    localparam logic [12:0] LD_WAIT = M_REA | M_MREQ;
    localparam logic [12:0] LD_DONE = M_REA | M_MREQ | M_WED | M_D1;
    localparam logic [12:0] ST_CYC  = M_REA | M_RED2B | M_MREQ | M_MWE;

    function automatic logic [12:0] exec_exp(input logic [2:0] op, input logic c);
        case (op)
            3'd0:    return M_REA | M_REB | M_WED;
            3'd3:    return M_REA7 | M_D3 | (c ? M_WE7 : ZERO);
            3'd4:    return M_REA | M_WE7;
            3'd5:    return M_WED | M_D3;
            default: return ZERO;
        endcase
    endfunction

    task automatic check(input string tag, input logic [12:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [12:0] exp);
        @(negedge CLK);
        check(tag, exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic restart();
        RESET_N = 1'b0;
        #1;
        check("reset_async", ZERO);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        RUN = 1'b1;
        MRDY = 1'b0;
        cyc("idle_run", ZERO);
        RUN = 1'b0;
    endtask

    // Runs one instruction from FETCH through to the next FETCH.
    task automatic do_instr(input logic [15:0] ir, input logic c,
                            input int fw, input int mw, input int hw);
        logic [2:0] op;
        op = ir[15:13];
        RUN = 1'($urandom);
        for (int i = 0; i < fw; i++) begin
            MRDY = 1'b0;
            cyc("fetch_wait", F_WAIT);
        end
        MRDY = 1'b1;
        IR = ir;
        cyc("fetch_done", F_DONE);
        MRDY = 1'($urandom);
        RUN = 1'($urandom);
        cyc("decode", ZERO);
        COND = c;
        case (op)
            3'd1: begin
                for (int i = 0; i < mw; i++) begin
                    MRDY = 1'b0;
                    cyc("load_wait", LD_WAIT);
                end
                MRDY = 1'b1;
                cyc("load_done", LD_DONE);
            end
            3'd2: begin
                for (int i = 0; i < mw; i++) begin
                    MRDY = 1'b0;
                    cyc("store_wait", ST_CYC);
                end
                MRDY = 1'b1;
                cyc("store_done", ST_CYC);
            end
            3'd6: begin
                for (int i = 0; i < 3; i++) begin
                    RUN = 1'($urandom);
                    MRDY = 1'($urandom);
                    cyc("reserved_fault", M_FAULT);
                end
            end
            3'd7: begin
                RUN = 1'b0;
                for (int i = 0; i < hw; i++) begin
                    MRDY = 1'($urandom);
                    cyc("halt_hold", M_HALTED);
                end
                RUN = 1'b1;
                cyc("halt_resume", M_HALTED);
                RUN = 1'b0;
            end
            default: begin
                MRDY = 1'($urandom);
                cyc("exec", exec_exp(op, c));
            end
        endcase
    endtask

    initial begin
        logic [2:0]  op;
        logic [15:0] rir;
        RESET_N = 1'b0;
        RUN = 1'b0;
        MRDY = 1'b0;
        COND = 1'b0;
        IR = 16'h0000;
        @(posedge CLK);
        #1;
        check("reset_state", ZERO);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        cyc("idle", ZERO);
        MRDY = 1'b1;
        cyc("idle_mrdy_ignored", ZERO);
        RUN = 1'b1;
        cyc("idle_run", ZERO);
        RUN = 1'b0;

        do_instr(16'h0000, 1'b0, 0, 0, 0);
        do_instr(16'h0000, 1'b0, 0, 0, 0);
        do_instr(16'h2000, 1'b0, 0, 3, 0);
        do_instr(16'h6000, 1'b0, 0, 0, 0);
        do_instr(16'h6000, 1'b1, 0, 0, 0);
        do_instr(16'hE000, 1'b0, 0, 0, 10);
        do_instr(16'h4123, 1'b0, 1, 2, 0);
        do_instr(16'h8070, 1'b1, 0, 0, 0);
        do_instr(16'hA380, 1'b0, 0, 0, 0);
        do_instr(16'h0380, 1'b0, TO, 0, 0);
        do_instr(16'h2000, 1'b0, 0, TO, 0);
        do_instr(16'h4000, 1'b0, 2, TO, 0);

        repeat (40) begin
            case ($urandom_range(0, 6))
                0: op = 3'd0;
                1: op = 3'd1;
                2: op = 3'd2;
                3: op = 3'd3;
                4: op = 3'd4;
                5: op = 3'd5;
                default: op = 3'd7;
            endcase
            rir = {op, 13'($urandom)};
            do_instr(rir, 1'($urandom), $urandom_range(0, TO), $urandom_range(0, TO),
                     $urandom_range(0, 3));
        end

        // FETCH stuck: TO+1 wait cycles, then sticky FAULT
        MRDY = 1'b0;
        for (int i = 0; i < TO + 1; i++) cyc("fetch_to_wait", F_WAIT);
        for (int i = 0; i < 4; i++) begin
            RUN = 1'($urandom);
            MRDY = 1'($urandom);
            cyc("fetch_to_fault", M_FAULT);
        end
        restart();

        // MEM stuck on a STORE
        MRDY = 1'b1;
        IR = 16'h4000;
        cyc("fetch_done", F_DONE);
        cyc("decode", ZERO);
        MRDY = 1'b0;
        for (int i = 0; i < TO + 1; i++) cyc("mem_to_wait", ST_CYC);
        cyc("mem_to_fault", M_FAULT);
        restart();

        // Reset while FETCH is waiting
        MRDY = 1'b0;
        cyc("fetch_wait", F_WAIT);
        restart();

        do_instr(16'hC000, 1'b1, 0, 0, 0);
        restart();
        do_instr(16'h0000, 1'b0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
